// File: rtl/rgb_hue_sequencer.sv
// rgb_hue_sequencer: colour-wheel / manual duty source for the RGB PWM stage.
// duty = {blue, green, red}, one nibble per channel, all outputs registered.
module rgb_hue_sequencer #(
   parameter int STEP_DIV = 4
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   input  logic        step_tick,
   input  logic        mode,
   input  logic        hold,
   input  logic [11:0] man_duty,
   output logic [11:0] duty,
   output logic        duty_valid,
   output logic [2:0]  seg,
   output logic        cycle_done
);
   localparam int DW = $clog2(STEP_DIV) + 1;
   logic [DW-1:0] div_ctr, div_n;
   logic [3:0]    r, g, b, r_n, g_n, b_n;
   logic [2:0]    seg_n;
   logic [11:0]   duty_n;
   logic          run, fire;
   assign run  = step_tick & ~mode & ~hold;
   assign fire = run & (div_ctr == DW'(STEP_DIV - 1));
   // The step that lands the ramping channel on its end value also advances seg.
   always_comb begin
      r_n    = r;
      g_n    = g;
      b_n    = b;
      seg_n  = seg;
      div_n  = run ? (fire ? '0 : div_ctr + DW'(1)) : div_ctr;
      if (fire)
         case (seg)
            3'd0: begin g_n = g + 4'd1; if (g == 4'd14) seg_n = 3'd1; end
            3'd1: begin r_n = r - 4'd1; if (r == 4'd1)  seg_n = 3'd2; end
            3'd2: begin b_n = b + 4'd1; if (b == 4'd14) seg_n = 3'd3; end
            3'd3: begin g_n = g - 4'd1; if (g == 4'd1)  seg_n = 3'd4; end
            3'd4: begin r_n = r + 4'd1; if (r == 4'd14) seg_n = 3'd5; end
            3'd5: begin b_n = b - 4'd1; if (b == 4'd1)  seg_n = 3'd0; end
            default: seg_n = 3'd0;
         endcase
      duty_n = mode ? man_duty : {b_n, g_n, r_n};
   end
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
      if (!CPU_RESETN) begin
         seg        <= 3'd0;
         r          <= 4'd15;
         g          <= 4'd0;
         b          <= 4'd0;
         div_ctr    <= '0;
         duty       <= 12'h00F;
         duty_valid <= 1'b0;
         cycle_done <= 1'b0;
      end else begin
         seg        <= seg_n;
         r          <= r_n;
         g          <= g_n;
         b          <= b_n;
         div_ctr    <= div_n;
         duty       <= duty_n;
         duty_valid <= duty_n != duty;
         cycle_done <= fire & (seg == 3'd5) & (seg_n == 3'd0);
      end
endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// tb_rgb_hue_sequencer: scoreboard bench; the wheel model derives colour from a step count.
module tb_rgb_hue_sequencer;
   localparam int SD = 4;
   logic        CLK100MHZ = 1'b0;
   logic        CPU_RESETN = 1'b0;
   logic        step_tick = 1'b0, mode = 1'b0, hold = 1'b0;
   logic [11:0] man_duty = '0;
   logic [11:0] duty;
   logic        duty_valid, cycle_done;
   logic [2:0]  seg;

   rgb_hue_sequencer #(.STEP_DIV(SD)) dut (
      .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .step_tick(step_tick),
      .mode(mode), .hold(hold), .man_duty(man_duty), .duty(duty),
      .duty_valid(duty_valid), .seg(seg), .cycle_done(cycle_done));

   always #5 CLK100MHZ = ~CLK100MHZ;

   typedef struct {logic [11:0] d; int c;} ev_t;
   ev_t q[$];
   ev_t mon_e;
   int n_cmp = 0, n_fail = 0, cyc = 0, n_valid = 0, n_cd = 0;
   int p = 0, d = 0;
   logic [11:0] exp_duty = 12'h00F;
   logic [2:0]  exp_seg = 3'd0;
   logic        exp_cd = 1'b0;
   logic        cur_mode = 1'b0, cur_hold = 1'b0;

   // Colour after p steps from reset: segment p/15, k steps into it.
   function automatic logic [11:0] wheel(input int pos);
      int s, k;
      logic [3:0] r, g, b;
      s = (pos % 90) / 15;
      k = pos % 15;
      r = 4'd0; g = 4'd0; b = 4'd0;
      case (s)
         0: begin r = 4'd15; g = 4'(k); end
         1: begin g = 4'd15; r = 4'(15 - k); end
         2: begin g = 4'd15; b = 4'(k); end
         3: begin b = 4'd15; g = 4'(15 - k); end
         4: begin b = 4'd15; r = 4'(k); end
         default: begin r = 4'd15; b = 4'(15 - k); end
      endcase
      return {b, g, r};
   endfunction

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   task automatic drive(input logic t, input logic m, input logic h, input logic [11:0] md);
      logic [11:0] nd;
      @(negedge CLK100MHZ);
      step_tick = t; mode = m; hold = h; man_duty = md;
      exp_cd = 1'b0;
      if (!m && !h && t) begin
         d++;
         if (d == SD) begin
            d = 0;
            p = (p + 1) % 90;
            exp_cd = (p == 0);
         end
      end
      nd = m ? md : wheel(p);
      if (nd != exp_duty) q.push_back('{nd, cyc + 1});
      exp_duty = nd;
      exp_seg = 3'(p / 15);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         drive(1'b1, 1'b0, 1'b0, 12'($urandom));
         repeat ($urandom_range(0, 1)) drive(1'b0, 1'b0, 1'b0, 12'($urandom));
      end
   endtask

   task automatic settle();
      @(posedge CLK100MHZ);
      #2;
   endtask

   task automatic do_reset();
      @(negedge CLK100MHZ);
      #2;
      CPU_RESETN = 1'b0;
      step_tick = 1'b0; mode = 1'b0; hold = 1'b0;
      #1;
      chk("async_rst_duty", 32'(duty), 32'h00F);
      chk("async_rst_seg", 32'(seg), 32'd0);
      chk("async_rst_valid", 32'(duty_valid), 32'd0);
      chk("async_rst_cycle_done", 32'(cycle_done), 32'd0);
      p = 0; d = 0; exp_duty = 12'h00F; exp_seg = 3'd0; exp_cd = 1'b0;
      q.delete();
      n_valid = 0; n_cd = 0;
      @(negedge CLK100MHZ);
      CPU_RESETN = 1'b1;
   endtask

   always @(posedge CLK100MHZ) begin
      #1;
      cyc++;
      if (CPU_RESETN) begin
         chk("seg", 32'(seg), 32'(exp_seg));
         chk("cycle_done", 32'(cycle_done), 32'(exp_cd));
         chk("duty", 32'(duty), 32'(exp_duty));
         if (cycle_done) n_cd++;
         if (duty_valid) begin
            n_valid++;
            if (q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL valid_spurious: duty_valid=1 duty=%h, expected no pulse (cycle %0d)", duty, cyc);
            end else begin
               mon_e = q.pop_front();
               chk("valid_duty", 32'(duty), 32'(mon_e.d));
               chk("valid_cycle", 32'(cyc), 32'(mon_e.c));
            end
         end else if (q.size() > 0 && q[0].c <= cyc) begin
            mon_e = q.pop_front();
            n_cmp++; n_fail++;
            $display("FAIL valid_missing: duty_valid=0, expected pulse with duty %h at cycle %0d", mon_e.d, mon_e.c);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected end before 5 ms");
      $fatal(1);
   end

   initial begin
      do_reset();
      // first step after 4 ticks, then segment boundaries and full wheel
      ticks(3);
      drive(1'b1, 1'b0, 1'b0, 12'h000);
      settle();
      chk("first_step_duty", 32'(duty), 32'h01F);
      chk("first_step_valid", 32'(duty_valid), 32'd1);
      chk("first_step_seg", 32'(seg), 32'd0);
      ticks(56);
      settle();
      chk("t60_duty", 32'(duty), 32'h0FF);
      chk("t60_seg", 32'(seg), 32'd1);
      ticks(60);
      settle();
      chk("t120_duty", 32'(duty), 32'h0F0);
      chk("t120_seg", 32'(seg), 32'd2);
      ticks(240);
      settle();
      chk("t360_duty", 32'(duty), 32'h00F);
      chk("t360_seg", 32'(seg), 32'd0);
      chk("t360_cycle_done_count", 32'(n_cd), 32'd1);
      chk("t360_valid_count", 32'(n_valid), 32'd90);
      // manual override mid seg 0, resume from same div_ctr
      do_reset();
      ticks(30);
      settle();
      chk("pre_man_duty", 32'(duty), 32'h07F);
      drive(1'b0, 1'b1, 1'b0, 12'hA53);
      settle();
      chk("man_duty", 32'(duty), 32'hA53);
      chk("man_valid", 32'(duty_valid), 32'd1);
      repeat (10) drive(1'b1, 1'b1, 1'b0, 12'hA53);
      settle();
      chk("man_steady_duty", 32'(duty), 32'hA53);
      chk("man_steady_valid", 32'(duty_valid), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 12'h000);
      settle();
      chk("resume_duty", 32'(duty), 32'h07F);
      chk("resume_valid", 32'(duty_valid), 32'd1);
      ticks(2);
      settle();
      chk("resume_step_duty", 32'(duty), 32'h08F);
      // hold freezes divider
      do_reset();
      ticks(14);
      settle();
      chk("pre_hold_duty", 32'(duty), 32'h03F);
      repeat (20) drive(1'b1, 1'b0, 1'b1, 12'h000);
      settle();
      chk("hold_duty", 32'(duty), 32'h03F);
      chk("hold_valid", 32'(duty_valid), 32'd0);
      ticks(1);
      settle();
      chk("post_hold_1", 32'(duty), 32'h03F);
      ticks(1);
      settle();
      chk("post_hold_2", 32'(duty), 32'h04F);
      // randomized traffic
      do_reset();
      repeat (3000) begin
         if ($urandom_range(0, 19) == 0) cur_mode = ~cur_mode;
         if ($urandom_range(0, 9) == 0) cur_hold = ~cur_hold;
         drive(1'($urandom_range(0, 1)), cur_mode, cur_hold,
               ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? exp_duty : wheel(p))
                                           : 12'($urandom));
      end
      drive(1'b0, 1'b0, 1'b0, 12'h000);
      // asynchronous reset mid seg 3
      do_reset();
      ticks(200);
      settle();
      chk("seg3_duty", 32'(duty), 32'hFA0);
      chk("seg3_seg", 32'(seg), 32'd3);
      do_reset();
      settle();
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/rgb_hue_sequencer.md
Name: rgb_hue_sequencer

Overview:
- Upstream duty source for the RGB LED PWM stage.
- Produces the 12-bit duty word {blue[11:8], green[7:4], red[3:0]}; each nibble is 0..15 on the PWM stage's 16-step on-window.
- Auto mode: walks a six-segment colour wheel, one step per STEP_DIV step_tick pulses.
- Manual mode: passes the switch word through, registered.

Parameters:
- STEP_DIV, 4: step_tick pulses per colour step. Legal range 1..255. 0 is illegal; the implementation is not required to handle it.

Ports:
- CLK100MHZ, input, 1: system clock. All logic is on the rising edge.
- CPU_RESETN, input, 1: asynchronous active-low reset.
- step_tick, input, 1: one-CLK100MHZ-cycle enable pulse from the slow-tick divider.
- mode, input, 1: 0 selects auto, 1 selects manual.
- hold, input, 1: 1 freezes auto progression.
- man_duty, input, 12: manual duty word {B,G,R}.
- duty, output, 12: registered duty word {B,G,R}.
- duty_valid, output, 1: one-cycle pulse in the same cycle a new duty value first appears.
- seg, output, 3: current auto segment, 0..5.
- cycle_done, output, 1: one-cycle pulse when the wheel wraps from segment 5 to segment 0.

Behaviour:
- Reset (asynchronous, CPU_RESETN low):
  - seg=0, R=15, G=0, B=0, so duty=12'h00F.
  - div_ctr=0, duty_valid=0, cycle_done=0.
  - Reset takes effect immediately, mid-ramp included. After release, the first step needs STEP_DIV fresh ticks.
- Divider:
  - In auto mode with hold=0, each step_tick increments div_ctr (width ceil(log2(STEP_DIV))+1).
  - A tick with div_ctr==STEP_DIV-1 sets div_ctr to 0 and fires one colour step.
  - With hold=1 or mode=1, ticks are ignored and div_ctr keeps its value.
- Auto segments. Each colour step moves the ramping channel by exactly 1:
  - seg 0: R=15, G ramps up 0 to 15.
  - seg 1: G=15, R ramps down 15 to 0.
  - seg 2: G=15, B ramps up 0 to 15.
  - seg 3: B=15, G ramps down 15 to 0.
  - seg 4: B=15, R ramps up 0 to 15.
  - seg 5: R=15, B ramps down 15 to 0.
- Segment transitions:
  - On the step that brings the ramping channel to its end value (15 up, 0 down), seg advances in the same edge.
  - Each segment therefore takes 15 steps; a full wheel takes 90 steps, i.e. 90*STEP_DIV ticks.
  - 5 to 0 wraps and pulses cycle_done in the same cycle duty returns to 12'h00F.
  - No channel ever leaves 0..15; ramps saturate by construction, not by wrap.
- Latency:
  - Auto: the firing tick at edge N gives the new duty and duty_valid=1 after edge N, i.e. 1 cycle.
  - Manual: man_duty sampled at edge N appears on duty after edge N.
- Manual mode (mode=1):
  - duty follows man_duty each cycle.
  - Auto state (seg, R/G/B, div_ctr) is frozen, not cleared.
  - Switching back to auto restores duty to the frozen auto colour on the next edge and pulses duty_valid if that value differs.
- duty_valid:
  - High for exactly one cycle whenever the registered duty changes value.
  - Never high when duty is unchanged, e.g. man_duty held steady or a manual value equal to the auto colour.
- Simultaneous events:
  - hold=1 with a firing tick: no step, div_ctr unchanged.
  - mode change and step_tick in the same cycle: the new mode governs that cycle's edge.
  - seg is always driven from auto state, including in manual mode.
- No combinational path from any input to any output.

Test Plan:
- Reset then STEP_DIV=4, 4 ticks, mode=0, hold=0 -> duty 12'h00F becomes 12'h01F with one duty_valid pulse on the 4th tick's following cycle; seg=0.
- 60 ticks from reset (15 steps) -> duty=12'h0FF, seg=1. Another 60 ticks -> duty=12'h0F0, seg=2.
- 360 ticks from reset -> exactly one cycle_done pulse, duty=12'h00F, seg=0; 90 duty_valid pulses total.
- Mid seg 0 at duty=12'h07F: mode=1, man_duty=12'hA53 -> duty=12'hA53 next cycle. Ticks ignored. mode=0 -> duty=12'h07F next cycle with valid pulse; progression resumes from the same div_ctr.
- hold=1 for 20 ticks at duty=12'h03F -> duty stays 12'h03F, no duty_valid. Release hold -> next step occurs after the remaining div_ctr ticks.
- CPU_RESETN low asynchronously mid seg 3 -> duty=12'h00F and seg=0 immediately without a clock edge; cycle_done=0, duty_valid=0.
